// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg
// Shared definitions for the memory-mapped interval timer: register word
// offsets, CTRL bit positions, the decoder base address and a byte-lane
// merge helper used for partial CPU writes.
package interval_timer_pkg;

  // Word offsets inside the timer window.
  typedef enum logic [1:0] {
    TIMER_CTRL   = 2'd0,
    TIMER_LOAD   = 2'd1,
    TIMER_COUNT  = 2'd2,
    TIMER_STATUS = 2'd3
  } timer_reg_e;

  // CTRL bit indices.
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_RELOAD = 1;
  localparam int unsigned CTRL_IE     = 2;
  localparam int unsigned CTRL_W      = 3;

  // Word address of the timer window, used by the system address decoder.
  localparam logic [29:0] TIMER_BASE_WADDR = 30'h4004;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [3:0]  be,
                                             input logic [31:0] new_val);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/interval_timer_prescaler.sv
// prescaler
// Divides clk_i into a one-cycle tick every PRESCALE cycles while run_i is
// high. The count restarts from 0 whenever run_i drops, so the first tick
// after enabling always lands exactly PRESCALE cycles later.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   run_i    count enable; low clears the prescaler
//   tick_o   one-cycle pulse on the wrap back to 0
module prescaler #(
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // Tick is asserted during the cycle in which the counter sits at its last
  // value; the consumer acts on it at the same edge that wraps the count.
  assign tick_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (run_i && !tick_o) cnt_d = cnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/interval_timer.sv
// interval_timer
// 32-bit down-counting interval timer on the CPU data bus.
// Registers: CTRL (EN/RELOAD/IE), LOAD, COUNT, STATUS (PEND, write-1-clear).
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   sel_i     decoder hit for the timer window
//   addr_i    word offset within the window
//   re_i      read strobe; rdata_o is valid the following cycle
//   we_i      byte write enables
//   wdata_i   write data
//   rdata_o   registered read data, held until the next read
//   irq_o     PEND & CTRL.IE
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic [1:0]  addr_i,
  input  logic        re_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       load_q, load_d;
  logic [31:0]       count_q, count_d;
  logic              pend_q, pend_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              tick;
  logic              pend_set;
  logic              pend_clr;
  timer_reg_e        reg_sel;

  assign reg_sel = timer_reg_e'(addr_i);

  prescaler #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .run_i  (ctrl_q[CTRL_EN]),
    .tick_o (tick)
  );

  always_comb begin
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;

    // Timer event first; CPU writes below overwrite it where they collide.
    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 32'd1;
      end else begin
        pend_set = 1'b1;
        if (ctrl_q[CTRL_RELOAD]) count_d = load_q;  // old LOAD on same-cycle write
        else                     ctrl_d[CTRL_EN] = 1'b0;
      end
    end

    if (sel_i) begin
      case (reg_sel)
        TIMER_CTRL:   if (we_i[0]) ctrl_d = wdata_i[CTRL_W-1:0];
        TIMER_LOAD:   load_d = byte_merge(load_q, we_i, wdata_i);
        // Merge against the current COUNT so a partial write also wins
        // over a same-cycle decrement or reload.
        TIMER_COUNT:  if (we_i != 4'b0) count_d = byte_merge(count_q, we_i, wdata_i);
        TIMER_STATUS: pend_clr = we_i[0] & wdata_i[0];
        default: ;
      endcase

      if (re_i) begin
        case (reg_sel)
          TIMER_CTRL:   rdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
          TIMER_LOAD:   rdata_d = load_q;
          TIMER_COUNT:  rdata_d = count_q;
          TIMER_STATUS: rdata_d = {31'b0, pend_q};
          default:      rdata_d = '0;
        endcase
      end
    end

    // A tick that sets PEND wins over a simultaneous clear.
    pend_d = pend_set | (pend_q & ~pend_clr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = pend_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer
// Directed scenarios followed by random bus traffic, all checked against a
// cycle-level behavioural model of the timer's register semantics.
module tb_interval_timer;

  localparam int P = 4;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [1:0]  addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata_o;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  interval_timer #(.PRESCALE(P), .PRESCALE_W(16)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sel_i   (sel),
    .addr_i  (addr),
    .re_i    (re),
    .we_i    (we),
    .wdata_i (wdata),
    .rdata_o (rdata_o),
    .irq_o   (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic        m_en, m_rl, m_ie;
  logic [31:0] m_load, m_count, m_rdata;
  logic        m_pend;
  int          m_age;  // cycles elapsed since the timer was last enabled

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_write(input logic [31:0] old_v, input logic [3:0] be,
                                             input logic [31:0] new_v);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {29'b0, m_ie, m_rl, m_en};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {31'b0, m_pend};
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_rl = 0; m_ie = 0;
    m_load = 0; m_count = 0; m_rdata = 0; m_pend = 0; m_age = 0;
  endtask

  task automatic model_step();
    logic        tick, n_en, n_rl, n_ie, n_pend, set_p, clr_p;
    logic [31:0] n_load, n_count;
    tick  = m_en && (((m_age + 1) % P) == 0);
    n_en = m_en; n_rl = m_rl; n_ie = m_ie;
    n_load = m_load; n_count = m_count;
    set_p = 0; clr_p = 0;
    if (sel && re) m_rdata = m_reg(addr);
    if (tick) begin
      if (m_count > 0) n_count = m_count - 1;
      else begin
        set_p = 1;
        if (m_rl) n_count = m_load;
        else      n_en = 0;
      end
    end
    if (sel) begin
      if (addr == 2'd0 && we[0]) {n_ie, n_rl, n_en} = wdata[2:0];
      if (addr == 2'd1) n_load = lane_write(m_load, we, wdata);
      if (addr == 2'd2 && we != 0) n_count = lane_write(m_count, we, wdata);
      if (addr == 2'd3) clr_p = we[0] && wdata[0];
    end
    n_pend = set_p ? 1'b1 : (clr_p ? 1'b0 : m_pend);
    m_age  = (m_en && n_en) ? m_age + 1 : 0;
    m_en = n_en; m_rl = n_rl; m_ie = n_ie;
    m_load = n_load; m_count = n_count; m_pend = n_pend;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("rdata", rdata_o, m_rdata);
    check_eq("irq", {31'b0, irq_o}, {31'b0, m_pend & m_ie});
  endtask

  task automatic idle(input int n);
    sel = 0; re = 0; we = 0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    sel = 1; addr = a; we = be; wdata = d; re = 0;
    step();
    sel = 0; we = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1; addr = a; re = 1; we = 0;
    step();
    d = rdata_o;
    sel = 0; re = 0;
  endtask

  logic [31:0] v;

  initial begin
    rst_n = 0; sel = 0; addr = 0; re = 0; we = 0; wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rdata", rdata_o, 32'h0);
    check_eq("reset_irq", {31'b0, irq_o}, 32'h0);
    @(negedge clk) rst_n = 1;

    // Every register reads zero after reset
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      check_eq("rst_read", v, 32'h0);
    end

    // Auto-reload countdown
    wr(2'd1, 4'hF, 3);
    wr(2'd2, 4'hF, 3);
    wr(2'd0, 4'h1, 7);
    idle(4);
    rd(2'd2, v); check_eq("cnt_2", v, 2);
    idle(3);
    rd(2'd2, v); check_eq("cnt_1", v, 1);
    idle(3);
    rd(2'd2, v); check_eq("cnt_0", v, 0);
    idle(4);
    check_eq("reload_irq", {31'b0, irq_o}, 1);
    rd(2'd3, v); check_eq("reload_pend", v, 1);
    rd(2'd2, v); check_eq("reload_cnt", v, 3);
    wr(2'd0, 4'h1, 0);
    wr(2'd3, 4'h1, 1);
    check_eq("clr_irq", {31'b0, irq_o}, 0);

    // One-shot
    wr(2'd2, 4'hF, 1);
    wr(2'd0, 4'h1, 1);
    idle(8);
    rd(2'd0, v); check_eq("os_ctrl", v, 0);
    rd(2'd3, v); check_eq("os_pend", v, 1);
    rd(2'd2, v); check_eq("os_cnt", v, 0);
    check_eq("os_irq", {31'b0, irq_o}, 0);
    wr(2'd3, 4'h1, 1);

    // W1C colliding with a PEND-setting tick
    wr(2'd1, 4'hF, 0);
    wr(2'd2, 4'hF, 0);
    wr(2'd0, 4'h1, 7);
    idle(3);
    wr(2'd3, 4'h1, 1);
    check_eq("w1c_tick_irq", {31'b0, irq_o}, 1);
    rd(2'd3, v); check_eq("w1c_tick_pend", v, 1);
    wr(2'd3, 4'h1, 1);
    check_eq("w1c_idle_irq", {31'b0, irq_o}, 0);
    rd(2'd3, v); check_eq("w1c_idle_pend", v, 0);
    wr(2'd0, 4'h1, 0);
    wr(2'd3, 4'h1, 1);
    rd(2'd3, v); check_eq("w1c_final", v, 0);

    // Byte-lane COUNT write beating a tick
    wr(2'd2, 4'hF, 32'h11223344);
    wr(2'd0, 4'h1, 1);
    idle(3);
    wr(2'd2, 4'b0010, 32'h0000AB00);
    rd(2'd2, v); check_eq("lane_cnt", v, 32'h1122AB44);
    wr(2'd0, 4'h1, 0);

    // Asynchronous reset mid-count
    wr(2'd2, 4'hF, 5);
    wr(2'd0, 4'h1, 1);
    rd(2'd2, v); check_eq("pre_rst_cnt", v, 5);
    #3 rst_n = 0;
    #1;
    check_eq("async_rdata", rdata_o, 0);
    check_eq("async_irq", {31'b0, irq_o}, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      check_eq("post_rst_read", v, 0);
    end
    wr(2'd2, 4'hF, 5);
    wr(2'd0, 4'h1, 1);
    idle(3);
    rd(2'd2, v); check_eq("no_early_tick", v, 5);
    rd(2'd2, v); check_eq("first_tick", v, 4);
    wr(2'd0, 4'h1, 0);

    // Random bus traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sel   = ($urandom_range(0, 9) != 0);
      addr  = 2'($urandom_range(0, 3));
      re    = 1'($urandom_range(0, 1));
      we    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      step();
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Memory-mapped 32-bit down-counting interval timer on the CPU data bus, alongside the UART, ms counter and output register.
- The system address decoder drives `sel` when the CPU address falls in the timer window.
- The decoder also forwards the low two word-address bits.
- Read data is registered so it appears on the cycle after the `re` tick, matching RAM read latency.
- Produces a level `irq` for a future interrupt input and a pending flag that firmware can poll.

Parameters:
- PRESCALE, 16, clk cycles per timer tick (>=1); 1 means one decrement per clk.
- PRESCALE_W, 16, width of the prescaler counter; must satisfy 2^PRESCALE_W >= PRESCALE.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sel  in  1  address decoder hit for the timer window.
- addr  in  2  word offset within the window.
- re  in  1  CPU read strobe (single-cycle tick).
- we  in  4  CPU byte write enables; we[i] covers wdata[8i+7:8i].
- wdata  in  32  CPU write data.
- rdata  out  32  registered read data.
- irq  out  1  pending & CTRL.IE.

Behaviour:
- Register map (word offset):
  - 0 CTRL: bit0 EN, bit1 RELOAD (auto-reload), bit2 IE; other bits read 0.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: 32-bit live counter.
  - 3 STATUS: bit0 PEND, write-1-to-clear; other bits read 0.
- Reset (reset==0, async):
  - CTRL=0, LOAD=0, COUNT=0, PEND=0, prescaler=0.
  - rdata=0, irq=0.
- Writes:
  - Take effect when sel & we[i] at posedge; byte lanes honoured for CTRL, LOAD and COUNT.
  - STATUS write: PEND cleared iff we[0] & wdata[0].
- Reads:
  - When sel & re, rdata latches the addressed register's value as seen before that edge's updates; rdata is valid on the next cycle.
  - rdata holds its value until the next sel & re.
  - No side effects on read.
- Prescaler:
  - Runs only while EN=1; counts 0..PRESCALE-1 and emits a one-cycle tick when it wraps to 0.
  - Clears to 0 when EN=0, and on any CTRL write that sets EN from 0.
  - First tick occurs PRESCALE cycles after enabling.
- Counter on tick (EN=1):
  - COUNT!=0: COUNT <= COUNT-1.
  - COUNT==0: PEND <= 1; then if RELOAD=1, COUNT <= LOAD; else EN <= 0 and COUNT stays 0 (one-shot).
- Simultaneous events:
  - CPU write to COUNT beats a tick decrement or reload in the same cycle.
  - Tick-set of PEND beats a W1C clear in the same cycle; no event is lost.
  - CPU write to CTRL beats the one-shot auto-clear of EN.
  - LOAD write and reload in the same cycle: the old LOAD is used.
- Wrap-around:
  - LOAD=0 with RELOAD=1 sets PEND on every tick.
  - COUNT never underflows past 0.
- irq: combinational from registered PEND and IE; no extra latency.
- sel=0: we and re are ignored entirely.

Decomposition:
- Shared package:
  - Register offset constants TIMER_CTRL=0, TIMER_LOAD=1, TIMER_COUNT=2, TIMER_STATUS=3.
  - CTRL bit indices EN/RELOAD/IE.
  - Timer window base word address 30'h4004 for the system decoder.
- Sub-module: `prescaler` (PRESCALE, PRESCALE_W; inputs clk, reset, run; output tick), reusable by the ms counter.
- Everything else stays in `interval_timer`.

Test Plan (PRESCALE=4):
- Reset then read every offset -> rdata=0 one cycle after each re, irq=0.
- Write LOAD=3 and COUNT=3, then CTRL=0x7 -> COUNT reads 2,1,0 at 4-cycle spacing; PEND=1 and irq=1 on the tick after 0; COUNT reloads to 3.
- One-shot: COUNT=1, CTRL=0x1 -> after 8 cycles PEND=1, CTRL reads 0, COUNT stays 0, irq=0 (IE clear).
- W1C of STATUS on the same cycle as a tick that sets PEND -> PEND remains 1; W1C on a later idle cycle -> PEND=0, irq drops the next cycle.
- Byte-lane write to COUNT with we=4'b0010, wdata=0x0000AB00, over COUNT=0x11223344 -> COUNT=0x1122AB44; a tick in the same cycle is ignored.
- Assert reset mid-count (COUNT=5, EN=1) -> all registers 0 immediately (async); no tick for PRESCALE cycles after EN is re-set.
